branch_predictor_btb: RTL and testbench

Parametrised branch target buffer with 2-bit saturating direction counters, predicting next-PC in IF for the MIPS pipeline. Branch/jump outcomes resolved in ID by the branch address calculation logic are written back through the update port. The block flags mispredictions with the correction address and keeps saturating statistics counters for the debug unit.

---
 rtl/branch_predictor_btb.sv | 141 ++++++++++++++
 tb/tb_branch_predictor_btb.sv | 259 +++++++++++++++++++++++++
 2 files changed

// File: rtl/branch_predictor_btb.sv
// Branch target buffer with 2-bit saturating direction counters.
// Predicts next PC in IF, takes resolved outcomes from ID, counts stats.
module branch_predictor_btb #(
    parameter int CANT_BITS_ADDR     = 11,
    parameter int CANT_ENTRADAS_BTB  = 16,
    parameter int CANT_BITS_INDEX    = 4,
    parameter int CANT_BITS_CONTADOR = 32
) (
    input  logic                          i_clock,
    input  logic                          i_reset,
    input  logic                          i_enable,
    input  logic                          i_flush_tabla,
    input  logic [CANT_BITS_ADDR-1:0]     i_pc_fetch,
    output logic                          o_prediccion_taken,
    output logic [CANT_BITS_ADDR-1:0]     o_pc_predicho,
    input  logic                          i_update_valid,
    input  logic [CANT_BITS_ADDR-1:0]     i_update_pc,
    input  logic                          i_update_taken,
    input  logic                          i_update_incondicional,
    input  logic [CANT_BITS_ADDR-1:0]     i_update_target,
    input  logic                          i_update_pred_taken,
    input  logic [CANT_BITS_ADDR-1:0]     i_update_pred_target,
    output logic                          o_mispredict,
    output logic [CANT_BITS_ADDR-1:0]     o_pc_correccion,
    output logic [CANT_BITS_CONTADOR-1:0] o_cant_branches,
    output logic [CANT_BITS_CONTADOR-1:0] o_cant_mispredicts
);

    localparam int TAG_W = CANT_BITS_ADDR - CANT_BITS_INDEX;
    localparam logic [CANT_BITS_ADDR-1:0] PC_UNO =
        {{(CANT_BITS_ADDR-1){1'b0}}, 1'b1};
    localparam logic [CANT_BITS_CONTADOR-1:0] CNT_UNO =
        {{(CANT_BITS_CONTADOR-1){1'b0}}, 1'b1};

    logic [CANT_ENTRADAS_BTB-1:0] r_valid;
    logic [TAG_W-1:0]             r_tag    [CANT_ENTRADAS_BTB];
    logic [CANT_BITS_ADDR-1:0]    r_target [CANT_ENTRADAS_BTB];
    logic [1:0]                   r_ctr    [CANT_ENTRADAS_BTB];

    logic [CANT_BITS_CONTADOR-1:0] r_cant_branches;
    logic [CANT_BITS_CONTADOR-1:0] r_cant_mispredicts;

    logic [CANT_BITS_INDEX-1:0] w_idx_fetch;
    logic [CANT_BITS_INDEX-1:0] w_idx_upd;
    logic [TAG_W-1:0]           w_tag_fetch;
    logic [TAG_W-1:0]           w_tag_upd;
    logic                       w_hit_fetch;
    logic                       w_hit_upd;
    logic                       w_upd_en;
    logic [1:0]                 w_ctr_upd;

    assign w_idx_fetch = i_pc_fetch[CANT_BITS_INDEX-1:0];
    assign w_tag_fetch = i_pc_fetch[CANT_BITS_ADDR-1:CANT_BITS_INDEX];
    assign w_idx_upd   = i_update_pc[CANT_BITS_INDEX-1:0];
    assign w_tag_upd   = i_update_pc[CANT_BITS_ADDR-1:CANT_BITS_INDEX];

    assign w_hit_fetch = r_valid[w_idx_fetch]
                      && (r_tag[w_idx_fetch] == w_tag_fetch);
    assign w_hit_upd   = r_valid[w_idx_upd]
                      && (r_tag[w_idx_upd] == w_tag_upd);
    assign w_ctr_upd   = r_ctr[w_idx_upd];

    // Flush wins over a same-cycle update; enable freezes everything.
    assign w_upd_en = i_enable && i_update_valid && !i_flush_tabla;

    // Lookup of the registered table, falling back to sequential PC.
    always_comb begin
        o_prediccion_taken = w_hit_fetch && r_ctr[w_idx_fetch][1];
        o_pc_predicho      = o_prediccion_taken ? r_target[w_idx_fetch]
                                                : i_pc_fetch + PC_UNO;
    end

    // Compare the IF-time prediction against the resolved outcome.
    always_comb begin
        o_mispredict    = 1'b0;
        o_pc_correccion = '0;
        if (i_update_valid) begin
            o_mispredict = (i_update_pred_taken != i_update_taken)
                        || (i_update_taken
                            && (i_update_pred_target != i_update_target));
            o_pc_correccion = i_update_taken ? i_update_target
                                             : i_update_pc + PC_UNO;
        end
    end

    // Table state: reset/flush invalidate, updates train or allocate.
    always_ff @(posedge i_clock or posedge i_reset) begin
        if (i_reset) begin
            r_valid <= '0;
            for (int i = 0; i < CANT_ENTRADAS_BTB; i++) begin
                r_tag[i]    <= '0;
                r_target[i] <= '0;
                r_ctr[i]    <= 2'b01;
            end
        end else if (i_enable && i_flush_tabla) begin
            r_valid <= '0;
            for (int i = 0; i < CANT_ENTRADAS_BTB; i++) begin
                r_ctr[i] <= 2'b01;
            end
        end else if (w_upd_en) begin
            if (w_hit_upd) begin
                if (i_update_incondicional) begin
                    r_ctr[w_idx_upd]    <= 2'b11;
                    r_target[w_idx_upd] <= i_update_target;
                end else if (i_update_taken) begin
                    if (w_ctr_upd != 2'b11) begin
                        r_ctr[w_idx_upd] <= w_ctr_upd + 2'b01;
                    end
                    r_target[w_idx_upd] <= i_update_target;
                end else if (w_ctr_upd != 2'b00) begin
                    r_ctr[w_idx_upd] <= w_ctr_upd - 2'b01;
                end
            end else if (i_update_taken) begin
                r_valid[w_idx_upd]  <= 1'b1;
                r_tag[w_idx_upd]    <= w_tag_upd;
                r_target[w_idx_upd] <= i_update_target;
                r_ctr[w_idx_upd]    <= i_update_incondicional ? 2'b11
                                                              : 2'b10;
            end
        end
    end

    // Saturating statistics for the debug unit.
    always_ff @(posedge i_clock or posedge i_reset) begin
        if (i_reset) begin
            r_cant_branches    <= '0;
            r_cant_mispredicts <= '0;
        end else if (w_upd_en) begin
            if (r_cant_branches != '1) begin
                r_cant_branches <= r_cant_branches + CNT_UNO;
            end
            if (o_mispredict && (r_cant_mispredicts != '1)) begin
                r_cant_mispredicts <= r_cant_mispredicts + CNT_UNO;
            end
        end
    end

    assign o_cant_branches    = r_cant_branches;
    assign o_cant_mispredicts = r_cant_mispredicts;

endmodule

// File: tb/tb_branch_predictor_btb.sv
// Directed bench for branch_predictor_btb with an expected-value queue.
// Counters use a narrow width so saturation is reachable quickly.
module tb_branch_predictor_btb;

    localparam int A = 11;
    localparam int C = 6;

    logic         i_clock;
    logic         i_reset;
    logic         i_enable;
    logic         i_flush_tabla;
    logic [A-1:0] i_pc_fetch;
    logic         o_prediccion_taken;
    logic [A-1:0] o_pc_predicho;
    logic         i_update_valid;
    logic [A-1:0] i_update_pc;
    logic         i_update_taken;
    logic         i_update_incondicional;
    logic [A-1:0] i_update_target;
    logic         i_update_pred_taken;
    logic [A-1:0] i_update_pred_target;
    logic         o_mispredict;
    logic [A-1:0] o_pc_correccion;
    logic [C-1:0] o_cant_branches;
    logic [C-1:0] o_cant_mispredicts;

    int n_assert = 0;
    int n_fail   = 0;
    logic [31:0] q_exp[$];

    branch_predictor_btb #(
        .CANT_BITS_ADDR(A),
        .CANT_ENTRADAS_BTB(16),
        .CANT_BITS_INDEX(4),
        .CANT_BITS_CONTADOR(C)
    ) dut (
        .i_clock(i_clock),
        .i_reset(i_reset),
        .i_enable(i_enable),
        .i_flush_tabla(i_flush_tabla),
        .i_pc_fetch(i_pc_fetch),
        .o_prediccion_taken(o_prediccion_taken),
        .o_pc_predicho(o_pc_predicho),
        .i_update_valid(i_update_valid),
        .i_update_pc(i_update_pc),
        .i_update_taken(i_update_taken),
        .i_update_incondicional(i_update_incondicional),
        .i_update_target(i_update_target),
        .i_update_pred_taken(i_update_pred_taken),
        .i_update_pred_target(i_update_pred_target),
        .o_mispredict(o_mispredict),
        .o_pc_correccion(o_pc_correccion),
        .o_cant_branches(o_cant_branches),
        .o_cant_mispredicts(o_cant_mispredicts)
    );

    initial i_clock = 1'b0;
    always #5 i_clock = ~i_clock;

    task automatic cyc();
        @(posedge i_clock);
        #1;
    endtask

    task automatic exp_v(input logic [31:0] v);
        q_exp.push_back(v);
    endtask

    task automatic chk(input string tag, input logic [31:0] obs);
        logic [31:0] e;
        n_assert++;
        if (q_exp.size() == 0) begin
            n_fail++;
            $error("FAIL %s no expected value queued, observed=%0h",
                   tag, obs);
        end else begin
            e = q_exp.pop_front();
            assert (obs === e) else begin
                n_fail++;
                $error("FAIL %s observed=%0h expected=%0h", tag, obs, e);
            end
        end
    endtask

    task automatic upd(input logic [A-1:0] pc, input logic tk,
                       input logic inc, input logic [A-1:0] tg,
                       input logic ptk, input logic [A-1:0] ptg);
        i_update_valid         = 1'b1;
        i_update_pc            = pc;
        i_update_taken         = tk;
        i_update_incondicional = inc;
        i_update_target        = tg;
        i_update_pred_taken    = ptk;
        i_update_pred_target   = ptg;
    endtask

    task automatic noupd();
        i_update_valid         = 1'b0;
        i_update_pc            = '0;
        i_update_taken         = 1'b0;
        i_update_incondicional = 1'b0;
        i_update_target        = '0;
        i_update_pred_taken    = 1'b0;
        i_update_pred_target   = '0;
        i_flush_tabla          = 1'b0;
    endtask

    task automatic lookup(input logic [A-1:0] pc, input logic et,
                          input logic [A-1:0] ep, input string tag);
        i_pc_fetch = pc;
        exp_v({31'd0, et});
        exp_v({21'd0, ep});
        #1;
        chk({tag, "_taken"}, {31'd0, o_prediccion_taken});
        chk({tag, "_pred"}, {21'd0, o_pc_predicho});
    endtask

    task automatic mis(input logic em, input logic [A-1:0] ec,
                       input string tag);
        exp_v({31'd0, em});
        exp_v({21'd0, ec});
        #1;
        chk({tag, "_mispredict"}, {31'd0, o_mispredict});
        chk({tag, "_corr"}, {21'd0, o_pc_correccion});
    endtask

    task automatic edge_stats(input int b, input int m, input string tag);
        exp_v(b);
        exp_v(m);
        cyc();
        noupd();
        #1;
        chk({tag, "_branches"}, {26'd0, o_cant_branches});
        chk({tag, "_mispred"}, {26'd0, o_cant_mispredicts});
    endtask

    initial begin
        i_reset    = 1'b1;
        i_enable   = 1'b1;
        noupd();
        i_pc_fetch = 11'h005;
        #3;
        exp_v(0);
        exp_v(0);
        chk("rst_branches", {26'd0, o_cant_branches});
        chk("rst_mispred", {26'd0, o_cant_mispredicts});
        lookup(11'h005, 1'b0, 11'h006, "rst_005");
        lookup(11'h7FF, 1'b0, 11'h000, "rst_wrap");
        mis(1'b0, 11'h000, "rst_noupd");
        @(negedge i_clock);
        i_reset = 1'b0;
        cyc();

        upd(11'h013, 1'b1, 1'b0, 11'h040, 1'b0, 11'h014);
        mis(1'b1, 11'h040, "first");
        lookup(11'h013, 1'b0, 11'h014, "same_idx_old");
        edge_stats(1, 1, "first");
        lookup(11'h013, 1'b1, 11'h040, "first_hit");

        upd(11'h013, 1'b0, 1'b0, 11'h040, 1'b1, 11'h040);
        mis(1'b1, 11'h014, "nt1");
        edge_stats(2, 2, "nt1");
        lookup(11'h013, 1'b0, 11'h014, "ctr01");

        upd(11'h013, 1'b0, 1'b0, 11'h040, 1'b0, 11'h014);
        mis(1'b0, 11'h014, "nt2");
        edge_stats(3, 2, "nt2");
        lookup(11'h013, 1'b0, 11'h014, "ctr00");

        upd(11'h013, 1'b1, 1'b0, 11'h040, 1'b0, 11'h014);
        mis(1'b1, 11'h040, "tk_again");
        edge_stats(4, 3, "tk_again");
        lookup(11'h013, 1'b0, 11'h014, "ctr01b");

        upd(11'h023, 1'b1, 1'b0, 11'h100, 1'b0, 11'h024);
        mis(1'b1, 11'h100, "alias");
        edge_stats(5, 4, "alias");
        lookup(11'h013, 1'b0, 11'h014, "alias_old");
        lookup(11'h023, 1'b1, 11'h100, "alias_new");

        upd(11'h023, 1'b1, 1'b0, 11'h120, 1'b1, 11'h100);
        mis(1'b1, 11'h120, "bad_tgt");
        edge_stats(6, 5, "bad_tgt");
        lookup(11'h023, 1'b1, 11'h120, "retarget");

        upd(11'h023, 1'b1, 1'b0, 11'h120, 1'b1, 11'h120);
        mis(1'b0, 11'h120, "good");
        edge_stats(7, 5, "good");

        upd(11'h030, 1'b1, 1'b1, 11'h200, 1'b0, 11'h031);
        mis(1'b1, 11'h200, "jump");
        edge_stats(8, 6, "jump");
        lookup(11'h030, 1'b1, 11'h200, "jump_hit");

        upd(11'h030, 1'b0, 1'b0, 11'h200, 1'b1, 11'h200);
        mis(1'b1, 11'h031, "jump_nt");
        edge_stats(9, 7, "jump_nt");
        lookup(11'h030, 1'b1, 11'h200, "jump_ctr11");

        upd(11'h050, 1'b1, 1'b0, 11'h300, 1'b0, 11'h051);
        i_flush_tabla = 1'b1;
        mis(1'b1, 11'h300, "flush");
        edge_stats(9, 7, "flush");
        lookup(11'h030, 1'b0, 11'h031, "flush_030");
        lookup(11'h023, 1'b0, 11'h024, "flush_023");
        lookup(11'h050, 1'b0, 11'h051, "flush_050");

        i_enable = 1'b0;
        upd(11'h013, 1'b1, 1'b0, 11'h040, 1'b0, 11'h014);
        mis(1'b1, 11'h040, "dis");
        edge_stats(9, 7, "dis");
        lookup(11'h013, 1'b0, 11'h014, "dis_tbl");
        i_enable = 1'b1;

        upd(11'h7FF, 1'b0, 1'b0, 11'h000, 1'b0, 11'h000);
        mis(1'b0, 11'h000, "corr_wrap");
        edge_stats(10, 7, "corr_wrap");

        upd(11'h013, 1'b1, 1'b0, 11'h040, 1'b0, 11'h014);
        @(negedge i_clock);
        i_reset = 1'b1;
        #1;
        exp_v(0);
        exp_v(0);
        chk("midrst_branches", {26'd0, o_cant_branches});
        chk("midrst_mispred", {26'd0, o_cant_mispredicts});
        @(negedge i_clock);
        i_reset = 1'b0;
        noupd();
        lookup(11'h013, 1'b0, 11'h014, "midrst_tbl");

        for (int k = 0; k < 62; k++) begin
            upd(11'h013, 1'b1, 1'b0, 11'h040, 1'b0, 11'h014);
            cyc();
        end
        noupd();
        exp_v(62);
        exp_v(62);
        #1;
        chk("near_sat_branches", {26'd0, o_cant_branches});
        chk("near_sat_mispred", {26'd0, o_cant_mispredicts});
        for (int k = 0; k < 8; k++) begin
            upd(11'h013, 1'b1, 1'b0, 11'h040, 1'b0, 11'h014);
            cyc();
        end
        noupd();
        exp_v(63);
        exp_v(63);
        #1;
        chk("sat_branches", {26'd0, o_cant_branches});
        chk("sat_mispred", {26'd0, o_cant_mispredicts});
        lookup(11'h013, 1'b1, 11'h040, "sat_tbl");

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_assert, n_fail);
        $finish;
    end

endmodule
